spi_reg_writer: RTL and testbench

//  SPI initiator (controller) that writes 8-bit configuration registers into the PWM SPI peripheral.

---
 rtl/spi_ctrl_pkg.sv | 22 ++
 rtl/spi_clk_div.sv | 31 +++
 rtl/spi_reg_writer.sv | 124 ++++++++++++
 tb/tb_spi_reg_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the PWM peripheral SPI write link: controller state encoding,
// frame layout and the peripheral's register map.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int   FRAME_W   = 16;
    localparam logic WRITE_BIT = 1'b1;

    localparam logic [6:0] REG_EN_OUT_7_0   = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8  = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0   = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8  = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY     = 7'h04;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period tick generator: tick_o pulses every CLK_DIV enabled cycles,
// clr_i synchronously restarts the count.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 controller writing one 16-bit frame {1,addr,data} per request to the PWM peripheral.
// Optional read-back capture of cipo into rx_data is enabled by defining SPI_CIPO_CAPTURE_EN.
module spi_reg_writer
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              copi,
    output logic              ncs
`ifdef SPI_CIPO_CAPTURE_EN
    ,
    input  logic              cipo,
    output logic [7:0]        rx_data
`endif
);

    state_t               state_q, state_d;
    logic                 phase_q, phase_d;
    logic [3:0]           bit_q, bit_d;
    logic [FRAME_W-1:0]   sreg_q, sreg_d;
    logic                 tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != ST_IDLE),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    // phase_q: 0 = sclk low half of the current bit, 1 = sclk high half
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_SETUP;
                    sreg_d  = {WRITE_BIT, req_addr, req_data};
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'(FRAME_W - 1)) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_HOLD: if (tick) state_d = ST_GAP;
            ST_GAP: begin
                if (tick) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
    end

    // Outputs decode straight from state so reset forces idle levels without waiting for a clock
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ncs       = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));
    assign sclk      = (state_q == ST_SHIFT) && phase_q;
    assign copi      = ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) ? sreg_q[FRAME_W-1] : 1'b0;

`ifdef SPI_CIPO_CAPTURE_EN
    logic [7:0] rx_sh_q;
    logic [7:0] rx_data_q;

    always_ff @(posedge clk) begin
        if ((state_q == ST_SHIFT) && !phase_q && tick) rx_sh_q <= {rx_sh_q[6:0], cipo};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rx_data_q <= '0;
        else if (done) rx_data_q <= rx_sh_q;
    end

    assign rx_data = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: a bus model rebuilds each SPI frame and it is
// compared against the frame queued when the request was driven.
module tb_spi_reg_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v4, v1;
    logic [6:0] a4, a1;
    logic [7:0] d4, d1;
    logic       rdy4, busy4, done4, sclk4, copi4, ncs4;
    logic       rdy1, busy1, done1, sclk1, copi1, ncs1;

    int         n4 = 0, n1 = 0;
    logic [15:0] sh4 = '0, sh1 = '0;
    int         idle_edges = 0;
    int         hc4 = 0, gap4 = 0;
    int         dc4 = 0;

`ifdef SPI_CIPO_CAPTURE_EN
    localparam logic [15:0] RESP4 = 16'h003C;
    logic       cipo4, cipo1;
    logic [7:0] rx4, rx1;
    assign cipo4 = (n4 < 16) ? RESP4[15-n4] : 1'b0;
    assign cipo1 = 1'b0;
`endif

    spi_reg_writer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_addr(a4), .req_data(d4),
        .busy(busy4), .done(done4), .sclk(sclk4), .copi(copi4), .ncs(ncs4)
`ifdef SPI_CIPO_CAPTURE_EN
        , .cipo(cipo4), .rx_data(rx4)
`endif
    );

    spi_reg_writer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_addr(a1), .req_data(d1),
        .busy(busy1), .done(done1), .sclk(sclk1), .copi(copi1), .ncs(ncs1)
`ifdef SPI_CIPO_CAPTURE_EN
        , .cipo(cipo1), .rx_data(rx1)
`endif
    );

    typedef struct {
        int          inst;
        int          edges;
        logic [15:0] frame;
    } frm_t;

    frm_t exp_q[$];
    frm_t obs_q[$];
    int compared = 0;
    int mismatched = 0;

    // Bus model: peripheral-side sampling on rising sclk while selected
    always @(negedge ncs4) begin n4 = 0; sh4 = '0; end
    always @(posedge sclk4) begin
        if (ncs4) idle_edges++;
        else begin sh4 = {sh4[14:0], copi4}; n4++; end
    end
    always @(posedge ncs4) if (!rst) obs_q.push_back('{0, n4, sh4});

    always @(negedge ncs1) begin n1 = 0; sh1 = '0; end
    always @(posedge sclk1) begin
        if (ncs1) idle_edges++;
        else begin sh1 = {sh1[14:0], copi1}; n1++; end
    end
    always @(posedge ncs1) if (!rst) obs_q.push_back('{1, n1, sh1});

    always @(negedge clk) begin
        if (done4) dc4++;
        if (ncs4) hc4++;
        else begin
            if (hc4 != 0) gap4 = hc4;
            hc4 = 0;
        end
    end

    task automatic send(input int inst, input logic [6:0] a, input logic [7:0] d,
                        input bit chain, input logic [6:0] na, input logic [7:0] nd,
                        output int lat);
        frm_t e;
        int   w;
        bit   seen;
        e.inst = inst; e.edges = 16; e.frame = {1'b1, a, d};
        exp_q.push_back(e);
        @(negedge clk);
        if (inst == 0) begin v4 = 1'b1; a4 = a; d4 = d; end
        else           begin v1 = 1'b1; a1 = a; d1 = d; end
        w = 0;
        while (!((inst == 0) ? rdy4 : rdy1)) begin
            @(negedge clk);
            w++;
            if (w > 500) begin
                compared++; mismatched++;
                $display("FAIL accept_timeout inst=%0d: ready never seen, required ready within 500 cycles", inst);
                lat = -1;
                return;
            end
        end
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) begin
                if (chain) begin
                    if (inst == 0) begin a4 = na; d4 = nd; end
                    else           begin a1 = na; d1 = nd; end
                end else begin
                    if (inst == 0) v4 = 1'b0; else v1 = 1'b0;
                end
            end
            if ((inst == 0) ? done4 : done1) begin seen = 1'b1; break; end
        end
        if (!seen) lat = -1;
    endtask

    task automatic get_frame(output frm_t o, output frm_t e, output bit got);
        got = 1'b0;
        e = '{-1, -1, 16'h0};
        o = '{-1, -1, 16'h0};
        for (int i = 0; i < 100 && obs_q.size() == 0; i++) @(negedge clk);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (obs_q.size() > 0) begin o = obs_q.pop_front(); got = 1'b1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v4 = 1'b0; a4 = '0; d4 = '0;
        v1 = 1'b0; a1 = '0; d1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        compared++; if (ncs4 !== 1'b1)  begin mismatched++; $display("FAIL reset_ncs got=%b want=1", ncs4); end
        compared++; if (sclk4 !== 1'b0) begin mismatched++; $display("FAIL reset_sclk got=%b want=0", sclk4); end
        compared++; if (copi4 !== 1'b0) begin mismatched++; $display("FAIL reset_copi got=%b want=0", copi4); end
        compared++; if (rdy4 !== 1'b1)  begin mismatched++; $display("FAIL reset_ready got=%b want=1", rdy4); end
        compared++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin mismatched++; $display("FAIL reset_busy_done got=%b%b want=00", busy4, done4); end
        compared++; if (ncs1 !== 1'b1 || sclk1 !== 1'b0) begin mismatched++; $display("FAIL reset_div1_idle got ncs=%b sclk=%b want 1/0", ncs1, sclk1); end
        compared++; if (idle_edges != 0) begin mismatched++; $display("FAIL reset_idle_edges got=%0d want=0", idle_edges); end
    endtask

    task automatic test_write();
        int lat; frm_t o, e; bit got;
        send(0, 7'h04, 8'h80, 1'b0, '0, '0, lat);
        compared++; if (lat != 140) begin mismatched++; $display("FAIL write_latency got=%0d want=140", lat); end
        get_frame(o, e, got);
        compared++; if (!got || o.frame !== e.frame || e.frame !== 16'h8480) begin mismatched++; $display("FAIL write_frame got=%h want=8480", o.frame); end
        compared++; if (o.edges != 16) begin mismatched++; $display("FAIL write_edges got=%0d want=16", o.edges); end
`ifdef SPI_CIPO_CAPTURE_EN
        @(negedge clk);
        compared++; if (rx4 !== 8'h3C) begin mismatched++; $display("FAIL cipo_rx_data got=%h want=3c", rx4); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat_a, lat_b; frm_t o, e; bit got;
        send(0, 7'h00, 8'hFF, 1'b1, 7'h02, 8'h0F, lat_a);
        send(0, 7'h02, 8'h0F, 1'b0, '0, '0, lat_b);
        compared++; if (lat_a != 140 || lat_b != 140) begin mismatched++; $display("FAIL b2b_latency got=%0d/%0d want=140/140", lat_a, lat_b); end
        get_frame(o, e, got);
        compared++; if (!got || o.frame !== e.frame || o.edges != 16) begin mismatched++; $display("FAIL b2b_frame0 got=%h/%0d want=%h/16", o.frame, o.edges, e.frame); end
        get_frame(o, e, got);
        compared++; if (!got || o.frame !== e.frame || o.edges != 16) begin mismatched++; $display("FAIL b2b_frame1 got=%h/%0d want=%h/16", o.frame, o.edges, e.frame); end
        compared++; if (gap4 != 5) begin mismatched++; $display("FAIL b2b_ncs_gap got=%0d want=5", gap4); end
    endtask

    task automatic test_clk_div1();
        int lat; frm_t o, e; bit got;
        send(1, 7'h01, 8'hA5, 1'b0, '0, '0, lat);
        compared++; if (lat != 35) begin mismatched++; $display("FAIL div1_latency got=%0d want=35", lat); end
        get_frame(o, e, got);
        compared++; if (!got || o.inst != 1 || o.frame !== 16'h81A5) begin mismatched++; $display("FAIL div1_frame got=%h want=81a5", o.frame); end
        compared++; if (o.edges != 16) begin mismatched++; $display("FAIL div1_edges got=%0d want=16", o.edges); end
    endtask

    task automatic test_reset_mid();
        int lat; int dc_before; bit hit; frm_t o, e; bit got;
        @(negedge clk);
        v4 = 1'b1; a4 = 7'h03; d4 = 8'h55;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy4) v4 = 1'b0;
            if (n4 == 8 && !ncs4) begin hit = 1'b1; break; end
        end
        compared++; if (!hit) begin mismatched++; $display("FAIL midrst_reach_bit7 got=%0d edges want=8", n4); end
        dc_before = dc4;
        #2 rst = 1'b1;
        #1;
        compared++; if (ncs4 !== 1'b1 || sclk4 !== 1'b0 || copi4 !== 1'b0) begin mismatched++; $display("FAIL midrst_idle got ncs=%b sclk=%b copi=%b want 1/0/0", ncs4, sclk4, copi4); end
        compared++; if (rdy4 !== 1'b1 || busy4 !== 1'b0) begin mismatched++; $display("FAIL midrst_ready got rdy=%b busy=%b want 1/0", rdy4, busy4); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        compared++; if (dc4 != dc_before) begin mismatched++; $display("FAIL midrst_no_done got=%0d want=%0d", dc4, dc_before); end
        compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL midrst_no_frame got=%0d frames want=0", obs_q.size()); end
        send(0, 7'h01, 8'h3C, 1'b0, '0, '0, lat);
        compared++; if (lat != 140) begin mismatched++; $display("FAIL midrst_next_latency got=%0d want=140", lat); end
        get_frame(o, e, got);
        compared++; if (!got || o.frame !== 16'h813C || o.edges != 16) begin mismatched++; $display("FAIL midrst_next_frame got=%h/%0d want=813c/16", o.frame, o.edges); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_clk_div1();
        test_reset_mid();
        repeat (5) @(negedge clk);
        compared++; if (idle_edges != 0) begin mismatched++; $display("FAIL final_idle_edges got=%0d want=0", idle_edges); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=no_finish want=finish");
        $fatal(1, "watchdog");
    end

endmodule
